dual_por_monitor: RTL and testbench



---
 rtl/por_pkg.sv | 14 +
 rtl/por_channel.sv | 55 +++++
 rtl/dual_por_monitor.sv | 50 +++++
 tb/tb_dual_por_monitor.sv | 118 +++++++++++
 4 files changed

// File: rtl/por_pkg.sv
// Shared constants and helpers for the dual power-on-reset monitor.
// Channel bit order throughout: [0] = core supply, [1] = auxiliary supply.
package por_pkg;

    localparam int SYNC_STAGES_DEF  = 2;
    localparam int DELAY_CYCLES_DEF = 16;
    localparam int CNT_W            = 8;

    // Each channel contributes {por, porb}, with channel 1 in the upper pair.
    function automatic logic [3:0] porb_to_checkbits(input logic [1:0] porb);
        return {~porb[1], porb[1], ~porb[0], porb[0]};
    endfunction

endpackage

// File: rtl/por_channel.sv
// One POR channel: input synchroniser, saturating stable-high counter,
// and the registered power-good flag.
module por_channel
    import por_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int DELAY_CYCLES = DELAY_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sense,
    output logic porb
);

    localparam logic [CNT_W-1:0] DELAY_MAX = CNT_W'(DELAY_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   porb_q;
    logic                   synced;
    logic                   at_max;

    assign synced = sync_q[SYNC_STAGES-1];
    assign at_max = (cnt_q == DELAY_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sense};
        end
    end

    // Any synchronised low restarts qualification from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!synced) begin
            cnt_q <= '0;
        end else if (!at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            porb_q <= 1'b0;
        end else begin
            porb_q <= synced & at_max;
        end
    end

    assign porb = porb_q;

endmodule

// File: rtl/dual_por_monitor.sv
// Two independent POR channels packed onto the HV status and LV checkbits
// readback buses, with the pad output-enable held off while in reset.
module dual_por_monitor
    import por_pkg::*;
#(
    parameter int DELAY_CYCLES = DELAY_CYCLES_DEF,
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [1:0] sense_i,
    output logic [1:0] porb_h_o,
    output logic [1:0] porb_l_o,
    output logic [1:0] por_l_o,
    output logic [1:0] status_o,
    output logic [3:0] checkbits_o,
    output logic [7:0] io_oeb_o
);

    logic [1:0] porb;
    logic [7:0] oeb_q;

    for (genvar n = 0; n < 2; n++) begin : g_ch
        por_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DELAY_CYCLES (DELAY_CYCLES)
        ) u_ch (
            .clk   (wb_clk_i),
            .rst   (wb_rst_i),
            .sense (sense_i[n]),
            .porb  (porb[n])
        );
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            oeb_q <= 8'hFF;
        end else begin
            oeb_q <= 8'h00;
        end
    end

    assign porb_h_o    = porb;
    assign porb_l_o    = porb;
    assign por_l_o     = ~porb;
    assign status_o    = porb;
    assign checkbits_o = porb_to_checkbits(porb);
    assign io_oeb_o    = oeb_q;

endmodule

// File: tb/tb_dual_por_monitor.sv
// Randomised bench for dual_por_monitor against a sample-history model:
// a channel is good when the last DELAY+1 samples, seen SYNC edges late, were all high.
module tb_dual_por_monitor;

    localparam int S    = 2;
    localparam int D    = 16;
    localparam int NMAX = 6000;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [1:0] sense_i  = 2'b00;
    logic [1:0] porb_h_o;
    logic [1:0] porb_l_o;
    logic [1:0] por_l_o;
    logic [1:0] status_o;
    logic [3:0] checkbits_o;
    logic [7:0] io_oeb_o;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    logic [1:0] hist [0:NMAX];

    dual_por_monitor dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .sense_i     (sense_i),
        .porb_h_o    (porb_h_o),
        .porb_l_o    (porb_l_o),
        .por_l_o     (por_l_o),
        .status_o    (status_o),
        .checkbits_o (checkbits_o),
        .io_oeb_o    (io_oeb_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge %0d got %h expected %h", tag, k, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [1:0] s);
        logic [1:0] g;
        logic [3:0] cb;
        @(negedge wb_clk_i);
        wb_rst_i = r;
        sense_i  = s;
        @(posedge wb_clk_i);
        if (k >= NMAX) begin
            $display("FAIL budget edge limit %0d reached", NMAX);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "edge budget exceeded");
        end
        k++;
        hist[k] = r ? 2'b00 : s;
        // Reset flushes samples still in flight through the synchroniser.
        if (r) begin
            for (int j = 1; j < S; j++) begin
                if (k - j >= 0) hist[k-j] = 2'b00;
            end
        end
        #1;
        for (int n = 0; n < 2; n++) begin
            g[n] = !r;
            for (int j = k - S - D; j <= k - S; j++) begin
                if (j < 1 || !hist[j][n]) g[n] = 1'b0;
            end
        end
        cb = {~g[1], g[1], ~g[0], g[0]};
        chk("status", {6'd0, status_o}, {6'd0, g});
        chk("checkbits", {4'd0, checkbits_o}, {4'd0, cb});
        chk("porb_h", {6'd0, porb_h_o}, {6'd0, g});
        chk("porb_l", {6'd0, porb_l_o}, {6'd0, g});
        chk("por_l", {6'd0, por_l_o}, {6'd0, ~g});
        chk("io_oeb", io_oeb_o, r ? 8'hFF : 8'h00);
    endtask

    task automatic run(input logic r, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) step(r, s);
    endtask

    initial begin
        for (int i = 0; i <= NMAX; i++) hist[i] = 2'b00;

        run(1'b1, 2'b11, 5);
        run(1'b0, 2'b01, 120);
        run(1'b0, 2'b11, 30);
        run(1'b0, 2'b01, 1);
        run(1'b0, 2'b11, 30);
        run(1'b0, 2'b10, 30);
        run(1'b1, 2'b10, 1);
        run(1'b0, 2'b00, 5);
        for (int r = 0; r < 8; r++) begin
            run(1'b0, 2'b01, 10);
            run(1'b0, 2'b00, 1);
        end

        for (int seg = 0; seg < 80; seg++) begin
            logic       rr;
            logic [1:0] ss;
            int         len;
            rr  = ($urandom_range(0, 15) == 0);
            ss  = 2'($urandom);
            len = rr ? 1 : int'($urandom_range(1, 40));
            run(rr, ss, len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
